cache_mem_arbiter: RTL and testbench

Arbitrates the single shared RAM port between icache and dcache block fills, write-backs and flushes. Holds a grant for a whole multi-word block transfer, so a dcache two-word write-back or fill is never interleaved with icache traffic. Sits between the caches and RAM, and generates the per-cache wait handshakes.

---
 rtl/cpu_types_pkg.sv | 33 +++
 rtl/arb_beat_counter.sv | 35 +++
 rtl/cache_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM arbitration slice: RAM status, arbiter state,
// port owner, and the debug view of the arbiter FSM.
package cpu_types_pkg;

    localparam int WORD_WIDTH = 32;

    typedef logic [WORD_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        ICACHE = 2'd1,
        DCACHE = 2'd2
    } owner_t;

    typedef struct packed {
        arb_state_t state;
        owner_t     owner;
    } arb_dbg_t;

endpackage

// File: rtl/arb_beat_counter.sv
// Counts completed RAM beats inside one grant; done_o flags the beat that
// finishes the block, after which the count wraps back to zero.
module arb_beat_counter #(
    parameter int BURST_LEN = 2,
    parameter int CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clear_i,
    output logic done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign done_o = inc_i && (cnt_q == CNT_W'(BURST_LEN - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = done_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port between icache and dcache, holding the grant for a whole
// block transfer. Define ARB_FAIR_EN for round-robin instead of dcache priority.
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int BURST_LEN = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 iREN,
    input  logic [WORD_W-1:0]    iaddr,
    output logic [WORD_W-1:0]    iload,
    output logic                 iwait,
    input  logic                 dREN,
    input  logic                 dWEN,
    input  logic [WORD_W-1:0]    daddr,
    input  logic [WORD_W-1:0]    dstore,
    output logic [WORD_W-1:0]    dload,
    output logic                 dwait,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [WORD_W-1:0]    ramaddr,
    output logic [WORD_W-1:0]    ramstore,
    input  logic [WORD_W-1:0]    ramload,
    input  ramstate_t            ramstate,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output arb_dbg_t             dbg_state
);

    // Handshake: a cache holds its strobe(s) high until it sees its wait low;
    // wait low marks the single cycle in which that word completes on the RAM.

    arb_state_t           state_q, state_d;
    owner_t               owner_q, owner_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 granted;
    logic                 own_req;
    logic                 d_req;
    logic                 d_first;
    logic                 beat_inc;
    logic                 beat_clear;
    logic                 beat_done;

    assign d_req   = dREN | dWEN;
    assign granted = (state_q != IDLE);
    assign own_req = (state_q == DGRANT) ? d_req :
                     (state_q == IGRANT) ? iREN : 1'b0;

    assign beat_inc   = granted && own_req && (ramstate == ACCESS);
    assign beat_clear = granted && !own_req;

`ifdef ARB_FAIR_EN
    logic last_d_q, last_d_d;

    // Contended arbitration favours whoever did not hold the last grant.
    assign d_first = ~last_d_q;

    always_comb begin
        last_d_d = last_d_q;
        if (state_q == IDLE && state_d != IDLE) begin
            last_d_d = (state_d == DGRANT);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    assign d_first = 1'b1;
`endif

    arb_beat_counter #(
        .BURST_LEN(BURST_LEN)
    ) u_beat_counter (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .inc_i   (beat_inc),
        .clear_i (beat_clear),
        .done_o  (beat_done)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        err_d   = err_q;
        if (granted && ramstate == ERROR && err_q != '1) begin
            err_d = err_q + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (d_req && (d_first || !iREN)) begin
                    state_d = DGRANT;
                    owner_d = DCACHE;
                end else if (iREN) begin
                    state_d = IGRANT;
                    owner_d = ICACHE;
                end
            end
            DGRANT, IGRANT: begin
                if (!own_req || beat_done) begin
                    state_d = IDLE;
                    owner_d = NONE;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = NONE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            owner_q <= NONE;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    // RAM pins follow the registered owner only, so a new request cannot reach them early.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        unique case (state_q)
            DGRANT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (ramstate == ACCESS) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (ramstate == ACCESS) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            default: begin
            end
        endcase
    end

    assign err_cnt         = err_q;
    assign dbg_state.state = state_q;
    assign dbg_state.owner = owner_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against a transaction-level owner model.
module tb_cache_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int BURST_LEN = 2;
    localparam int ERR_MAX   = 255;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    ramstate_t   ramstate;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [7:0]  err_cnt;
    arb_dbg_t    dbg_state;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    cache_mem_arbiter #(.WORD_W(32), .BURST_LEN(BURST_LEN), .ERR_CNT_W(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err_cnt(err_cnt), .dbg_state(dbg_state)
    );

    typedef struct {
        logic        nrst, iren, dren, dwen;
        logic [31:0] ia, da, ds, rl;
        ramstate_t   rs;
        arb_state_t  e_state;
        logic        e_iw, e_dw, e_ren, e_wen;
        logic [31:0] e_addr, e_store, e_il, e_dl;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge and let them settle.
    task automatic step(input logic nrst, input logic ir, input logic dr, input logic dw,
                        input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                        input ramstate_t rs, input logic [31:0] rl);
        @(negedge CLK);
        nRST = nrst; iREN = ir; dREN = dr; dWEN = dw;
        iaddr = ia; daddr = da; dstore = ds; ramstate = rs; ramload = rl;
        #1;
    endtask

    task automatic check_outs(input string tag, input arb_state_t es,
                              input logic eiw, input logic edw, input logic eren, input logic ewen,
                              input logic [31:0] eaddr, input logic [31:0] estore,
                              input logic [31:0] eil, input logic [31:0] edl, input int eerr);
        owner_t eo;
        eo = (es == DGRANT) ? DCACHE : (es == IGRANT) ? ICACHE : NONE;
        chk({tag, ".state"},    32'(dbg_state.state), 32'(es));
        chk({tag, ".owner"},    32'(dbg_state.owner), 32'(eo));
        chk({tag, ".iwait"},    32'(iwait),  32'(eiw));
        chk({tag, ".dwait"},    32'(dwait),  32'(edw));
        chk({tag, ".ramREN"},   32'(ramREN), 32'(eren));
        chk({tag, ".ramWEN"},   32'(ramWEN), 32'(ewen));
        chk({tag, ".ramaddr"},  ramaddr,  eaddr);
        chk({tag, ".ramstore"}, ramstore, estore);
        chk({tag, ".iload"},    iload,    eil);
        chk({tag, ".dload"},    dload,    edl);
        chk({tag, ".err_cnt"},  32'(err_cnt), 32'(eerr));
    endtask

    task automatic set_vec(input int i, input logic nrst, input logic ir, input logic dr, input logic dw,
                           input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                           input ramstate_t rs, input logic [31:0] rl,
                           input arb_state_t es, input logic eiw, input logic edw,
                           input logic eren, input logic ewen, input logic [31:0] eaddr,
                           input logic [31:0] estore, input logic [31:0] eil, input logic [31:0] edl);
        vecs[i].nrst = nrst; vecs[i].iren = ir; vecs[i].dren = dr; vecs[i].dwen = dw;
        vecs[i].ia = ia; vecs[i].da = da; vecs[i].ds = ds; vecs[i].rs = rs; vecs[i].rl = rl;
        vecs[i].e_state = es; vecs[i].e_iw = eiw; vecs[i].e_dw = edw;
        vecs[i].e_ren = eren; vecs[i].e_wen = ewen; vecs[i].e_addr = eaddr;
        vecs[i].e_store = estore; vecs[i].e_il = eil; vecs[i].e_dl = edl;
    endtask

    // Reference model: who owns the port, how many words of the block are done.
    int m_owner;   // 0 none, 1 icache, 2 dcache
    int m_beats;
    int m_err;
    bit m_last_d;

    task automatic model_update();
        bit dreq, pick_d, req;
        if (!nRST) begin
            m_owner = 0; m_beats = 0; m_err = 0; m_last_d = 0;
        end else if (m_owner == 0) begin
            dreq = dREN || dWEN;
`ifdef ARB_FAIR_EN
            pick_d = dreq && (!iREN || !m_last_d);
`else
            pick_d = dreq;
`endif
            if (pick_d) begin
                m_owner = 2; m_last_d = 1;
            end else if (iREN) begin
                m_owner = 1; m_last_d = 0;
            end
        end else begin
            if (ramstate == ERROR && m_err < ERR_MAX) m_err++;
            req = (m_owner == 2) ? (dREN || dWEN) : iREN;
            if (!req) begin
                m_owner = 0; m_beats = 0;
            end else if (ramstate == ACCESS) begin
                m_beats++;
                if (m_beats == BURST_LEN) begin
                    m_owner = 0; m_beats = 0;
                end
            end
        end
    endtask

    task automatic model_check(input int cyc);
        arb_state_t  es;
        logic        eiw, edw, eren, ewen;
        logic [31:0] eaddr, estore, eil, edl;
        es = IDLE; eiw = 1; edw = 1; eren = 0; ewen = 0;
        eaddr = 0; estore = 0; eil = 0; edl = 0;
        if (m_owner == 2) begin
            es = DGRANT; ewen = dWEN; eren = dREN && !dWEN;
            eaddr = daddr; estore = dstore;
            if (ramstate == ACCESS) begin edw = 0; edl = ramload; end
        end else if (m_owner == 1) begin
            es = IGRANT; eren = iREN; eaddr = iaddr;
            if (ramstate == ACCESS) begin eiw = 0; eil = ramload; end
        end
        check_outs($sformatf("rnd%0d", cyc), es, eiw, edw, eren, ewen, eaddr, estore, eil, edl, m_err);
    endtask

    initial begin
        // Directed table: icache fill, dirty write-back lock, contention, read+write collision.
        set_vec(0,  0,1,0,0, 32'h100,0,0, FREE,0,            IDLE,  1,1,0,0, 0,0,0,0);
        set_vec(1,  1,1,0,0, 32'h100,0,0, ACCESS,32'hAAAA,   IDLE,  1,1,0,0, 0,0,0,0);
        set_vec(2,  1,1,0,0, 32'h100,0,0, ACCESS,32'h1111,   IGRANT,0,1,1,0, 32'h100,0,32'h1111,0);
        set_vec(3,  1,1,0,0, 32'h104,0,0, ACCESS,32'h2222,   IGRANT,0,1,1,0, 32'h104,0,32'h2222,0);
        set_vec(4,  1,0,0,0, 0,0,0, FREE,0,                  IDLE,  1,1,0,0, 0,0,0,0);
        set_vec(5,  1,1,0,1, 32'h300,32'h200,32'hD0, ACCESS,32'h55, IDLE, 1,1,0,0, 0,0,0,0);
        set_vec(6,  1,1,0,1, 32'h300,32'h200,32'hD0, ACCESS,32'h55, DGRANT,1,0,0,1, 32'h200,32'hD0,0,32'h55);
        set_vec(7,  1,1,0,1, 32'h300,32'h204,32'hD1, ACCESS,32'h66, DGRANT,1,0,0,1, 32'h204,32'hD1,0,32'h66);
        set_vec(8,  1,1,0,0, 32'h300,32'h204,32'hD1, ACCESS,32'h77, IDLE, 1,1,0,0, 0,0,0,0);
        set_vec(9,  1,1,0,0, 32'h300,0,0, ACCESS,32'h88,     IGRANT,0,1,1,0, 32'h300,0,32'h88,0);
        set_vec(10, 1,0,0,0, 32'h300,0,0, FREE,0,            IGRANT,1,1,0,0, 32'h300,0,0,0);
        set_vec(11, 1,0,0,0, 0,0,0, FREE,0,                  IDLE,  1,1,0,0, 0,0,0,0);
        set_vec(12, 1,0,1,0, 0,32'h400,0, FREE,0,            IDLE,  1,1,0,0, 0,0,0,0);
        set_vec(13, 1,0,1,0, 0,32'h400,0, ACCESS,32'h99,     DGRANT,1,0,1,0, 32'h400,0,0,32'h99);
        set_vec(14, 1,1,1,0, 32'h500,32'h404,0, ACCESS,32'hAB, DGRANT,1,0,1,0, 32'h404,0,0,32'hAB);
        set_vec(15, 1,1,1,0, 32'h500,32'h408,0, FREE,0,      IDLE,  1,1,0,0, 0,0,0,0);
`ifdef ARB_FAIR_EN
        set_vec(16, 1,1,1,0, 32'h500,32'h408,0, BUSY,0,      IGRANT,1,1,1,0, 32'h500,0,0,0);
        set_vec(17, 1,0,0,0, 32'h500,32'h408,0, FREE,0,      IGRANT,1,1,0,0, 32'h500,0,0,0);
`else
        set_vec(16, 1,1,1,0, 32'h500,32'h408,0, BUSY,0,      DGRANT,1,1,1,0, 32'h408,0,0,0);
        set_vec(17, 1,0,0,0, 32'h500,32'h408,0, FREE,0,      DGRANT,1,1,0,0, 32'h408,0,0,0);
`endif
        set_vec(18, 1,0,0,0, 0,0,0, FREE,0,                  IDLE,  1,1,0,0, 0,0,0,0);
        set_vec(19, 1,0,1,1, 0,32'h600,32'hEE, FREE,0,       IDLE,  1,1,0,0, 0,0,0,0);
        set_vec(20, 1,0,1,1, 0,32'h600,32'hEE, ACCESS,32'h12, DGRANT,1,0,0,1, 32'h600,32'hEE,0,32'h12);
        set_vec(21, 1,0,0,0, 0,32'h600,32'hEE, FREE,0,       DGRANT,1,1,0,0, 32'h600,32'hEE,0,0);
        set_vec(22, 1,0,0,0, 0,0,0, FREE,0,                  IDLE,  1,1,0,0, 0,0,0,0);

        nRST = 0; iREN = 1; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
        repeat (2) @(posedge CLK);

        for (int i = 0; i < 23; i++) begin
            step(vecs[i].nrst, vecs[i].iren, vecs[i].dren, vecs[i].dwen,
                 vecs[i].ia, vecs[i].da, vecs[i].ds, vecs[i].rs, vecs[i].rl);
            check_outs($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_iw, vecs[i].e_dw,
                       vecs[i].e_ren, vecs[i].e_wen, vecs[i].e_addr, vecs[i].e_store,
                       vecs[i].e_il, vecs[i].e_dl, 0);
        end

        // RAM errors during a dcache grant: stall, count, retry, then complete.
        step(1,0,1,0, 0,32'h700,0, FREE,0);
        check_outs("err_idle", IDLE, 1,1,0,0, 0,0,0,0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1,0,1,0, 0,32'h700,0, ERROR,32'h5);
            check_outs($sformatf("err%0d", k), DGRANT, 1,1,1,0, 32'h700,0,0,0, k);
        end
        step(1,0,1,0, 0,32'h700,0, ACCESS,32'h3C);
        check_outs("err_done", DGRANT, 1,0,1,0, 32'h700,0,0,32'h3C, 3);
        step(1,0,0,0, 0,32'h700,0, FREE,0);
        check_outs("err_drop", DGRANT, 1,1,0,0, 32'h700,0,0,0, 3);
        step(1,0,0,0, 0,0,0, FREE,0);
        check_outs("err_rel", IDLE, 1,1,0,0, 0,0,0,0, 3);

        // Error counter saturation with the grant held throughout.
        step(1,0,1,0, 0,32'h710,0, FREE,0);
        repeat (260) step(1,0,1,0, 0,32'h710,0, ERROR,0);
        step(1,0,1,0, 0,32'h710,0, ERROR,0);
        check_outs("err_sat", DGRANT, 1,1,1,0, 32'h710,0,0,0, ERR_MAX);
        step(1,0,0,0, 0,32'h710,0, FREE,0);
        step(1,0,0,0, 0,0,0, FREE,0);
        check_outs("sat_rel", IDLE, 1,1,0,0, 0,0,0,0, ERR_MAX);

        // Reset after the first beat of a dcache read aborts the block.
        step(1,0,1,0, 0,32'h800,0, FREE,0);
        step(1,0,1,0, 0,32'h800,0, ACCESS,32'h42);
        check_outs("rst_beat1", DGRANT, 1,0,1,0, 32'h800,0,0,32'h42, ERR_MAX);
        step(0,0,1,0, 0,32'h804,0, ACCESS,32'h43);
        step(1,0,1,0, 0,32'h804,0, ACCESS,32'h44);
        check_outs("rst_abort", IDLE, 1,1,0,0, 0,0,0,0, 0);

        // Random traffic against the model, starting from a clean reset.
        step(0,0,0,0, 0,0,0, FREE,0);
        step(0,0,0,0, 0,0,0, FREE,0);
        m_owner = 0; m_beats = 0; m_err = 0; m_last_d = 0;
        begin
            logic ir, dr, dw, nr;
            int r;
            ramstate_t rs;
            ir = 0; dr = 0; dw = 0;
            for (int cyc = 0; cyc < 400; cyc++) begin
                if ($urandom_range(0, 4) == 0) ir = ~ir;
                if ($urandom_range(0, 4) == 0) dr = ~dr;
                if ($urandom_range(0, 5) == 0) dw = ~dw;
                nr = ($urandom_range(0, 99) >= 3);
                r  = $urandom_range(0, 7);
                rs = (r < 4) ? ACCESS : (r == 4) ? ERROR : (r == 5) ? BUSY : FREE;
                step(nr, ir, dr, dw, $urandom, $urandom, $urandom, rs, $urandom);
                model_check(cyc);
                model_update();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
